// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
// Optional abort support is enabled by defining PULSE_TRAIN_ABORT_EN.
package pulse_train_pkg;

   localparam int DEF_CNT_W   = 8;
   localparam int DEF_WIDTH_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing the current HIGH or LOW phase.
// A load takes priority; otherwise the count decrements until it reaches zero.
module pulse_phase_timer
   import pulse_train_pkg::*;
#(
   parameter int WIDTH_W = DEF_WIDTH_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [WIDTH_W-1:0] value,
   output logic               zero
);

   logic [WIDTH_W-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits N registered pulses of programmable high/low width with start/busy/done.
// Define PULSE_TRAIN_ABORT_EN to add the abort input that cancels a running train.
module pulse_train_gen
   import pulse_train_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int WIDTH_W = DEF_WIDTH_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CNT_W-1:0]   pulse_count,
   input  logic [WIDTH_W-1:0] high_len,
   input  logic [WIDTH_W-1:0] low_len,
`ifdef PULSE_TRAIN_ABORT_EN
   input  logic               abort,
`endif
   output logic               signal_out,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   pulses_sent
);

   state_t             state_reg, state_next;
   logic               out_reg, out_next;
   logic               done_reg, done_next;
   logic [CNT_W-1:0]   sent_reg, sent_next;
   logic [CNT_W-1:0]   n_reg;
   logic [WIDTH_W-1:0] h_m1_reg, l_m1_reg;
   logic [WIDTH_W-1:0] h_in_m1, l_in_m1;
   logic               accept;
   logic               timer_load;
   logic [WIDTH_W-1:0] timer_value;
   logic               timer_zero;
   logic               abort_req;

`ifdef PULSE_TRAIN_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Phase lengths are stored as (length - 1) with a zero length treated as one.
   assign h_in_m1 = (high_len == '0) ? '0 : high_len - 1'b1;
   assign l_in_m1 = (low_len  == '0) ? '0 : low_len  - 1'b1;

   pulse_phase_timer #(
      .WIDTH_W (WIDTH_W)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .value (timer_value),
      .zero  (timer_zero)
   );

   always_comb begin
      state_next  = state_reg;
      out_next    = out_reg;
      done_next   = 1'b0;
      sent_next   = sent_reg;
      accept      = 1'b0;
      timer_load  = 1'b0;
      timer_value = '0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (pulse_count != '0) begin
                  accept      = 1'b1;
                  state_next  = HIGH;
                  out_next    = 1'b1;
                  sent_next   = CNT_W'(1);
                  timer_load  = 1'b1;
                  timer_value = h_in_m1;
               end else begin
                  done_next = 1'b1;
                  sent_next = '0;
               end
            end
         end
         HIGH: begin
            if (abort_req) begin
               state_next = IDLE;
               out_next   = 1'b0;
            end else if (timer_zero) begin
               state_next  = LOW;
               out_next    = 1'b0;
               timer_load  = 1'b1;
               timer_value = l_m1_reg;
            end
         end
         LOW: begin
            if (abort_req) begin
               state_next = IDLE;
               out_next   = 1'b0;
            end else if (timer_zero) begin
               if (sent_reg < n_reg) begin
                  state_next  = HIGH;
                  out_next    = 1'b1;
                  sent_next   = sent_reg + 1'b1;
                  timer_load  = 1'b1;
                  timer_value = h_m1_reg;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            out_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         out_reg   <= 1'b0;
         done_reg  <= 1'b0;
         sent_reg  <= '0;
         n_reg     <= '0;
         h_m1_reg  <= '0;
         l_m1_reg  <= '0;
      end else begin
         state_reg <= state_next;
         out_reg   <= out_next;
         done_reg  <= done_next;
         sent_reg  <= sent_next;
         if (accept) begin
            n_reg    <= pulse_count;
            h_m1_reg <= h_in_m1;
            l_m1_reg <= l_in_m1;
         end
      end
   end

   assign signal_out  = out_reg;
   assign busy        = (state_reg != IDLE);
   assign done        = done_reg;
   assign pulses_sent = sent_reg;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomized and directed bench for pulse_train_gen using an arithmetic reference model.
// Define PULSE_TRAIN_ABORT_EN to also exercise the abort input.
module tb_pulse_train_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pulse_count = '0;
   logic [3:0] high_len = '0;
   logic [3:0] low_len = '0;
`ifdef PULSE_TRAIN_ABORT_EN
   logic       abort = 1'b0;
`endif
   logic       signal_out;
   logic       busy;
   logic       done;
   logic [7:0] pulses_sent;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pulse_train_gen #(
      .CNT_W   (8),
      .WIDTH_W (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pulse_count (pulse_count),
      .high_len    (high_len),
      .low_len     (low_len),
`ifdef PULSE_TRAIN_ABORT_EN
      .abort       (abort),
`endif
      .signal_out  (signal_out),
      .busy        (busy),
      .done        (done),
      .pulses_sent (pulses_sent)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input int n, input int hl, input int ll);
      start       = 1'b1;
      pulse_count = n[7:0];
      high_len    = hl[3:0];
      low_len     = ll[3:0];
   endtask

   // Expected output at t cycles after acceptance follows from period P=H+L:
   // high while (t mod P) < H, pulse index t/P+1, done exactly at t = N*P.
   task automatic run_train(input int n, input int hl, input int ll, input bit noise,
                            input bit started, input bit chain,
                            input int nn, input int nh, input int nl);
      int h, l, p, tt;
      h  = (hl == 0) ? 1 : hl;
      l  = (ll == 0) ? 1 : ll;
      p  = h + l;
      tt = n * p;
      if (!started) begin
         @(negedge clk);
         drive_start(n, hl, ll);
      end
      for (int t = 0; t <= tt; t++) begin
         @(negedge clk);
         start       = 1'b0;
         pulse_count = 8'($urandom);
         high_len    = 4'($urandom);
         low_len     = 4'($urandom);
         if (noise && t < tt && $urandom_range(0, 2) == 0) start = 1'b1;
         if (t < tt) begin
            chk("out", 32'(signal_out), 32'((t % p) < h));
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("sent", 32'(pulses_sent), 32'(t / p + 1));
         end else begin
            chk("out_end", 32'(signal_out), 32'd0);
            chk("busy_end", 32'(busy), 32'd0);
            chk("done", 32'(done), 32'd1);
            chk("sent_end", 32'(pulses_sent), 32'(n));
            if (chain) drive_start(nn, nh, nl);
         end
      end
      if (!chain) begin
         @(negedge clk);
         chk("done_width", 32'(done), 32'd0);
         chk("busy_idle", 32'(busy), 32'd0);
         chk("out_idle", 32'(signal_out), 32'd0);
         chk("sent_hold", 32'(pulses_sent), 32'(n));
      end
   endtask

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_out", 32'(signal_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sent", 32'(pulses_sent), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_out", 32'(signal_out), 32'd0);

      // directed trains
      run_train(3, 2, 2, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      run_train(0, 3, 3, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      run_train(4, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      run_train(3, 2, 2, 1'b1, 1'b0, 1'b0, 0, 0, 0);
      run_train(2, 1, 3, 1'b0, 1'b0, 1'b1, 3, 2, 1);
      run_train(3, 2, 1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
      run_train(255, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

      // randomized trains
      for (int i = 0; i < 10; i++) begin
         run_train(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), 1'($urandom), 1'b0, 1'b0, 0, 0, 0);
      end

      // reset during the high phase of pulse 2
      @(negedge clk);
      drive_start(3, 2, 2);
      for (int t = 0; t <= 4; t++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("pre_rst_out", 32'(signal_out), 32'd1);
      chk("pre_rst_sent", 32'(pulses_sent), 32'd2);
      reset = 1'b0;
      #1;
      chk("mid_rst_out", 32'(signal_out), 32'd0);
      chk("mid_rst_sent", 32'(pulses_sent), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(done), 32'd0);
         chk("post_rst_out", 32'(signal_out), 32'd0);
      end

`ifdef PULSE_TRAIN_ABORT_EN
      // abort in LOW after pulse 2 of a 5-pulse train
      @(negedge clk);
      drive_start(5, 2, 2);
      for (int t = 0; t <= 6; t++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("pre_abort_out", 32'(signal_out), 32'd0);
      chk("pre_abort_sent", 32'(pulses_sent), 32'd2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out", 32'(signal_out), 32'd0);
      chk("abort_sent", 32'(pulses_sent), 32'd2);
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         chk("abort_done", 32'(done), 32'd0);
      end
      // abort together with start in IDLE: start wins
      @(negedge clk);
      drive_start(1, 1, 1);
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abst_busy", 32'(busy), 32'd1);
      chk("abst_out", 32'(signal_out), 32'd1);
      @(negedge clk);
      chk("abst_low", 32'(signal_out), 32'd0);
      @(negedge clk);
      chk("abst_done", 32'(done), 32'd1);
      chk("abst_sent", 32'(pulses_sent), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
